evt_frame_tracker: RTL
======================

Name: evt_frame_tracker

Overview:
- Sits directly downstream of the wrapping event counter. Takes the same event strobe and the counter's current value, and turns the linear count into frame coordinates (x, y).
- Produces line-end and frame-end pulses and a frame counter.
- Checks that the counter value stays in lock-step with its own expected address. Flags and resynchronises on any slip, so the consumers (frame buffer writer, overlay logic) never get misaligned addresses.

Parameters:
- H_ACTIVE, 200, events per line (x range 0..H_ACTIVE-1)
- V_ACTIVE, 200, lines per frame (y range 0..V_ACTIVE-1)
- MAX_EVENT, H_ACTIVE*V_ACTIVE, wrap value of upstream counter; count_in width is $clog2(MAX_EVENT)
- FRAME_W, 16, width of frame counter

Ports:
- clk_in, input, 1, system clock
- rst_in, input, 1, synchronous active-high reset
- evt_in, input, 1, event strobe, same signal that drives the upstream counter
- count_in, input, $clog2(MAX_EVENT), upstream counter value in the cycle evt_in is high (pre-increment value = address of this event)
- valid_out, output, 1, registered: coordinates below are valid this cycle
- addr_out, output, $clog2(MAX_EVENT), linear address of the emitted event
- x_out, output, $clog2(H_ACTIVE), column
- y_out, output, $clog2(V_ACTIVE), row
- line_end_out, output, 1, high with valid_out when x_out==H_ACTIVE-1
- frame_end_out, output, 1, high with valid_out when addr_out==MAX_EVENT-1
- frame_count_out, output, FRAME_W, completed frames since reset, wraps modulo 2^FRAME_W
- sync_err_out, output, 1, single-cycle pulse on detected slip
- locked_out, output, 1, high while in TRACK

Behaviour:
- Clock and reset: one clock, clk_in; reset is synchronous and active-high on rst_in. While rst_in is high:
  - all outputs go to 0
  - state goes to SEEK
  - internal exp_addr, exp_x and exp_y go to 0
  - evt_in is ignored in that cycle
- Latency: all outputs are registered, one cycle after the evt_in cycle. There is no backpressure; one event can be accepted every cycle.
- Default: every pulse output (valid_out, line_end_out, frame_end_out, sync_err_out) is 0 in any cycle not driven by an event.
- FSM states: SEEK, TRACK.
- SEEK:
  - evt_in with count_in==0: emit (valid_out=1, addr 0, x 0, y 0); set exp_addr=1, exp_x=1 (or exp_x=0, exp_y=1 if H_ACTIVE==1); go to TRACK.
  - evt_in with count_in!=0: discard, no output, no sync_err.
  - locked_out=0.
- TRACK, evt_in with count_in==exp_addr:
  - Emit exp_x, exp_y, exp_addr.
  - Advance x; on exp_x==H_ACTIVE-1, set exp_x=0 and increment exp_y, with line_end_out=1.
  - On exp_addr==MAX_EVENT-1: frame_end_out=1, frame_count_out increments, exp_addr, exp_x and exp_y return to 0, and the block stays in TRACK.
  - exp_addr increments by 1 otherwise.
- TRACK, evt_in with count_in!=exp_addr:
  - sync_err_out=1 for one cycle and frame_count_out is unchanged.
  - If count_in==0: relock immediately. Emit it as address 0 (valid_out=1), set exp_addr=1 and stay in TRACK.
  - Otherwise: no valid_out, go to SEEK, locked_out drops in the next cycle.
- Arithmetic:
  - x and y are maintained by increment/compare only; no divider or multiplier.
  - All compares are against parameter constants.
  - exp_addr never exceeds MAX_EVENT-1.
- Boundaries:
  - frame_count_out wraps from 2^FRAME_W-1 to 0 silently.
  - Idle cycles (evt_in=0) of any length leave all state unchanged.
  - Back-to-back events every cycle are fully supported.
  - Reset mid-frame discards the partial frame; frame_count_out returns to 0.

Test Plan:
- Clean frame: reset, then drive MAX_EVENT=40000 consecutive events with count_in 0..39999.
  - 40000 valid_out pulses; x/y sweep row-major.
  - 200 line_end_out pulses, the last at (199,199).
  - One frame_end_out; frame_count_out=1; no sync_err_out.
- Mid-stream lock: start with count_in=57, 58, … then 0 after wrap.
  - No valid_out until count_in==0; locked_out rises the cycle after that event.
- Slip to nonzero: in TRACK at exp_addr=300, drive count_in=302.
  - sync_err_out pulse; no valid_out; state SEEK; later count_in=5 is ignored.
- Slip to zero: in TRACK at exp_addr=1000, drive count_in=0.
  - sync_err_out and valid_out in the same cycle with x=0, y=0; next count_in=1 is accepted; frame_count_out unchanged.
- Gapped events: insert 1–7 idle cycles randomly between events for 3 frames.
  - Outputs match gap-free reference; frame_count_out=3.
- Reset mid-frame: assert rst_in at addr 12345 with evt_in high.
  - Next cycle all outputs 0; locked_out=0.
  - Frame_count_out is reached via FRAME_W=2 over 5 frames: wraps 3→0→1.

Source files
------------

// File: rtl/evt_frame_tracker.sv
// Follows a wrapping event counter and turns each counted event into frame coordinates.
// Detects when the upstream count slips away from the expected address, and resynchronises.
module evt_frame_tracker #(
  parameter int unsigned H_ACTIVE  = 200,
  parameter int unsigned V_ACTIVE  = 200,
  parameter int unsigned MAX_EVENT = H_ACTIVE * V_ACTIVE,
  parameter int unsigned FRAME_W   = 16,
  localparam int unsigned AW = (MAX_EVENT > 1) ? $clog2(MAX_EVENT) : 1,
  localparam int unsigned XW = (H_ACTIVE  > 1) ? $clog2(H_ACTIVE)  : 1,
  localparam int unsigned YW = (V_ACTIVE  > 1) ? $clog2(V_ACTIVE)  : 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               evt_in,
  input  logic [AW-1:0]      count_in,
  output logic               valid_out,
  output logic [AW-1:0]      addr_out,
  output logic [XW-1:0]      x_out,
  output logic [YW-1:0]      y_out,
  output logic               line_end_out,
  output logic               frame_end_out,
  output logic [FRAME_W-1:0] frame_count_out,
  output logic               sync_err_out,
  output logic               locked_out
);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [AW-1:0] A_LAST = AW'(MAX_EVENT - 1);

  typedef enum logic {S_SEEK, S_TRACK} state_e;

  state_e state_q, state_d;

  logic [AW-1:0]      exp_addr_q, exp_addr_d;
  logic [XW-1:0]      exp_x_q,    exp_x_d;
  logic [YW-1:0]      exp_y_q,    exp_y_d;
  logic               valid_q,    valid_d;
  logic [AW-1:0]      addr_q,     addr_d;
  logic [XW-1:0]      x_q,        x_d;
  logic [YW-1:0]      y_q,        y_d;
  logic               line_end_q, line_end_d;
  logic               frame_end_q, frame_end_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               sync_err_q, sync_err_d;

  logic          in_track, hit, slip, zero_lock, emit;
  logic [AW-1:0] cur_a;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          last_x, last_a;

  // An event at address 0 always (re)starts tracking, whether from SEEK or as a slip in TRACK.
  always_comb begin
    in_track  = (state_q == S_TRACK);
    hit       = evt_in && in_track && (count_in == exp_addr_q);
    slip      = evt_in && in_track && (count_in != exp_addr_q);
    zero_lock = evt_in && (count_in == '0) && (!in_track || slip);
    emit      = hit || zero_lock;
    cur_a     = hit ? exp_addr_q : '0;
    cur_x     = hit ? exp_x_q    : '0;
    cur_y     = hit ? exp_y_q    : '0;
    last_x    = (cur_x == X_LAST);
    last_a    = (cur_a == A_LAST);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_SEEK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SEEK:  if (zero_lock) state_d = S_TRACK;
      S_TRACK: if (slip && (count_in != '0)) state_d = S_SEEK;
    endcase
  end

  always_comb begin
    valid_d     = emit;
    sync_err_d  = slip;
    line_end_d  = emit && last_x;
    frame_end_d = emit && last_a;
    addr_d      = addr_q;
    x_d         = x_q;
    y_d         = y_q;
    exp_addr_d  = exp_addr_q;
    exp_x_d     = exp_x_q;
    exp_y_d     = exp_y_q;
    frame_cnt_d = frame_cnt_q;
    if (emit) begin
      addr_d = cur_a;
      x_d    = cur_x;
      y_d    = cur_y;
      if (last_a) begin
        exp_addr_d = '0;
        exp_x_d    = '0;
        exp_y_d    = '0;
        if (!slip) frame_cnt_d = frame_cnt_q + 1'b1;
      end else begin
        exp_addr_d = cur_a + 1'b1;
        exp_x_d    = last_x ? '0 : cur_x + 1'b1;
        exp_y_d    = last_x ? cur_y + 1'b1 : cur_y;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      exp_addr_q  <= '0;
      exp_x_q     <= '0;
      exp_y_q     <= '0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      frame_cnt_q <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      exp_addr_q  <= exp_addr_d;
      exp_x_q     <= exp_x_d;
      exp_y_q     <= exp_y_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      frame_cnt_q <= frame_cnt_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign valid_out       = valid_q;
  assign addr_out        = addr_q;
  assign x_out           = x_q;
  assign y_out           = y_q;
  assign line_end_out    = line_end_q;
  assign frame_end_out   = frame_end_q;
  assign frame_count_out = frame_cnt_q;
  assign sync_err_out    = sync_err_q;
  assign locked_out      = (state_q == S_TRACK);

endmodule
